// File: rtl/ad7760_bus_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ad7760_bus_sched
// Purpose  : Shares the AD7760 parallel bus (cs_n / r_n_w / 16-bit data)
//            between a control-register write port and a DRDY-triggered
//            32-bit sample read. Every transaction is timed in clock cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sysclk_50          in   clock (the only clock)
//   i_rest             in   synchronous active-high reset
//   cfg_req            in   register-write request
//   cfg_addr/cfg_data  in   register address/value, latched on acceptance
//   cfg_ready          out  write port can accept a request this cycle
//   cfg_done           out  one-cycle pulse when a write returns to IDLE
//   rd_en              in   enables sample reads; 0 also clears overrun
//   drdy_n             in   asynchronous ADC data-ready (active low)
//   cs_n, r_n_w        out  ADC chip select / direction (1 = write)
//   bus_oe, bus_dout   out  drive enable and data for the write path
//   bus_din            in   read data from the ADC
//   smp_data/smp_valid out  captured sample {MSW, LSW} and its valid pulse
//   overrun            out  sticky: a DRDY fall was dropped
// ============================================================================
module ad7760_bus_sched #(
  parameter int CS_LOW_CYC = 8,
  parameter int CS_GAP_CYC = 8,
  parameter int SETTLE_CYC = 6,
  parameter int RD_CYC     = 2
) (
  input  logic        sysclk_50,
  input  logic        i_rest,
  input  logic        cfg_req,
  input  logic [15:0] cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_ready,
  output logic        cfg_done,
  input  logic        rd_en,
  input  logic        drdy_n,
  output logic        cs_n,
  output logic        r_n_w,
  output logic        bus_oe,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  output logic [31:0] smp_data,
  output logic        smp_valid,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_ADDR   = 3'd1;
  localparam logic [2:0] S_W_GAP    = 3'd2;
  localparam logic [2:0] S_W_VAL    = 3'd3;
  localparam logic [2:0] S_W_SETTLE = 3'd4;
  localparam logic [2:0] S_RD_HI    = 3'd5;
  localparam logic [2:0] S_RD_GAP   = 3'd6;
  localparam logic [2:0] S_RD_LO    = 3'd7;

  // Terminal counts: the counter runs 0..N-1 inside a state.
  localparam logic [7:0] C_LOW_LAST    = 8'(CS_LOW_CYC - 1);
  localparam logic [7:0] C_GAP_LAST    = 8'(CS_GAP_CYC - 1);
  localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] C_RD_LAST     = 8'(RD_CYC - 1);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [7:0]  cnt;
  logic        cnt_last;
  logic        rd_pend;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        fall;
  logic        accept;
  logic        in_read;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] addr_nx;
  logic [15:0] msw_q;

  // Output values for the coming cycle, registered below.
  logic        cs_n_d;
  logic        r_n_w_d;
  logic        bus_oe_d;
  logic [15:0] bus_dout_d;
  logic        done_d;
  logic        valid_d;

  assign fall    = sync3 & ~sync2 & rd_en;
  assign in_read = (state == S_RD_HI) || (state == S_RD_GAP) || (state == S_RD_LO);

  // A fall seen this very cycle already claims the bus, so the write port
  // is held off even before rd_pend has been registered.
  assign cfg_ready = (state == S_IDLE) && !rd_pend && !fall && !i_rest;
  assign accept    = cfg_ready && cfg_req;
  assign addr_nx   = accept ? cfg_addr : addr_q;

  always_comb begin
    cnt_last = 1'b0;
    case (state)
      S_W_ADDR, S_W_VAL:  cnt_last = (cnt == C_LOW_LAST);
      S_W_GAP:            cnt_last = (cnt == C_GAP_LAST);
      S_W_SETTLE:         cnt_last = (cnt == C_SETTLE_LAST);
      S_RD_HI, S_RD_LO:   cnt_last = (cnt == C_RD_LAST);
      S_RD_GAP:           cnt_last = 1'b1;
      default:            cnt_last = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (rd_pend || fall) next_state = S_RD_HI;
        else if (cfg_req)    next_state = S_W_ADDR;
      end
      S_W_ADDR:   if (cnt_last) next_state = S_W_GAP;
      S_W_GAP:    if (cnt_last) next_state = S_W_VAL;
      S_W_VAL:    if (cnt_last) next_state = S_W_SETTLE;
      S_W_SETTLE: if (cnt_last) next_state = S_IDLE;
      S_RD_HI:    if (cnt_last) next_state = S_RD_GAP;
      S_RD_GAP:   if (cnt_last) next_state = S_RD_LO;
      S_RD_LO:    if (cnt_last) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Decoded from next_state so the registered pins change on the same edge
  // the state does (cs_n falls on the edge that enters a low phase).
  always_comb begin
    cs_n_d     = 1'b1;
    r_n_w_d    = 1'b1;
    bus_oe_d   = 1'b0;
    bus_dout_d = 16'h0000;
    case (next_state)
      S_W_ADDR: begin
        cs_n_d     = 1'b0;
        bus_oe_d   = 1'b1;
        bus_dout_d = addr_nx;
      end
      S_W_VAL: begin
        cs_n_d     = 1'b0;
        bus_oe_d   = 1'b1;
        bus_dout_d = data_q;
      end
      S_RD_HI, S_RD_LO: begin
        cs_n_d  = 1'b0;
        r_n_w_d = 1'b0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
    done_d  = (state == S_W_SETTLE) && (next_state == S_IDLE);
    valid_d = (state == S_RD_LO) && (next_state == S_IDLE);
  end

  // ----------------------------------------------------------- state register
  always_ff @(posedge sysclk_50) begin
    if (i_rest) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      cs_n      <= 1'b1;
      r_n_w     <= 1'b1;
      bus_oe    <= 1'b0;
      bus_dout  <= 16'h0000;
      cfg_done  <= 1'b0;
      smp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      // Reload on every state change; IDLE keeps it parked at zero.
      if (next_state != state)  cnt <= 8'd0;
      else if (state != S_IDLE) cnt <= cnt + 8'd1;
      cs_n      <= cs_n_d;
      r_n_w     <= r_n_w_d;
      bus_oe    <= bus_oe_d;
      bus_dout  <= bus_dout_d;
      cfg_done  <= done_d;
      smp_valid <= valid_d;
    end
  end

  // ------------------------------------------------ DRDY sync, pending, data
  always_ff @(posedge sysclk_50) begin
    if (i_rest) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync3    <= 1'b1;
      rd_pend  <= 1'b0;
      overrun  <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      msw_q    <= 16'h0000;
      smp_data <= 32'h0000_0000;
    end else begin
      sync1 <= drdy_n;
      sync2 <= sync1;
      sync3 <= sync2;

      // A fall that cannot be queued (one already waiting, or a read on the
      // bus) is dropped and recorded in overrun.
      if (next_state == S_RD_HI && state != S_RD_HI) rd_pend <= 1'b0;
      else if (fall && !rd_pend && !in_read)          rd_pend <= 1'b1;

      if (!rd_en)                            overrun <= 1'b0;
      else if (fall && (rd_pend || in_read)) overrun <= 1'b1;

      if (accept) begin
        addr_q <= cfg_addr;
        data_q <= cfg_data;
      end

      if (state == S_RD_HI && cnt_last) msw_q <= bus_din;
      if (state == S_RD_LO && cnt_last) smp_data <= {msw_q, bus_din};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad7760_bus_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ad7760_bus_sched
// Purpose  : Self-checking bench for ad7760_bus_sched. Directed stimulus
//            pushes expected cfg_done / smp_valid events (with their cycle)
//            into a queue; a monitor pops and compares them when they occur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad7760_bus_sched;

  logic        sysclk_50 = 1'b0;
  logic        i_rest    = 1'b1;
  logic        cfg_req   = 1'b0;
  logic [15:0] cfg_addr  = 16'h0000;
  logic [15:0] cfg_data  = 16'h0000;
  logic        rd_en     = 1'b1;
  logic        drdy_n    = 1'b1;
  logic [15:0] bus_din;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cs_n;
  logic        r_n_w;
  logic        bus_oe;
  logic [15:0] bus_dout;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic        overrun;

  ad7760_bus_sched dut (
    .sysclk_50 (sysclk_50),
    .i_rest    (i_rest),
    .cfg_req   (cfg_req),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .rd_en     (rd_en),
    .drdy_n    (drdy_n),
    .cs_n      (cs_n),
    .r_n_w     (r_n_w),
    .bus_oe    (bus_oe),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .overrun   (overrun)
  );

  always #5 sysclk_50 = ~sysclk_50;

  int cyc = 0;
  always @(posedge sysclk_50) cyc <= cyc + 1;

  // ADC model: MSW during the first read low phase, LSW during the second.
  logic [15:0] cur_msw = 16'h0000;
  logic [15:0] cur_lsw = 16'h0000;
  logic        rd_half = 1'b0;
  logic        seen_low = 1'b0;
  assign bus_din = rd_half ? cur_lsw : cur_msw;
  always @(negedge sysclk_50) begin
    if (!cs_n && !r_n_w) seen_low = 1'b1;
    else if (seen_low && cs_n) begin
      rd_half  = ~rd_half;
      seen_low = 1'b0;
    end
  end

  typedef struct {
    bit          is_smp;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void push_exp(bit is_smp, logic [31:0] d, int at);
    exp_t e;
    e.is_smp = is_smp;
    e.data   = d;
    e.at     = at;
    sb.push_back(e);
  endfunction

  // Monitor: bus-direction invariant every cycle, events against scoreboard.
  always @(negedge sysclk_50) begin
    exp_t e;
    n_chk++;
    if (bus_oe === 1'b1 && r_n_w === 1'b0) begin
      n_fail++;
      $display("FAIL oe_during_read: bus_oe=%0b r_n_w=%0b cycle=%0d, required not both", bus_oe, r_n_w, cyc);
    end
    if (smp_valid === 1'b1 || cfg_done === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: smp_valid=%0b cfg_done=%0b cycle=%0d, required no event", smp_valid, cfg_done, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_smp !== smp_valid || e.is_smp === cfg_done ||
            (e.is_smp && smp_data !== e.data) || cyc != e.at) begin
          n_fail++;
          $display("FAIL sb_event: got smp_valid=%0b cfg_done=%0b data=0x%08h cycle=%0d, required %s data=0x%08h cycle=%0d",
                   smp_valid, cfg_done, smp_data, cyc, e.is_smp ? "smp_valid" : "cfg_done", e.data, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sysclk_50);
    #1;
  endtask

  // Called just after a rising edge. Returns the acceptance edge number.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input bit expect_done, output int acc_at);
    int waited;
    bit got;
    waited   = 0;
    got      = 1'b0;
    acc_at   = -1;
    cfg_addr = a;
    cfg_data = d;
    cfg_req  = 1'b1;
    while (!got && waited < 200) begin
      @(negedge sysclk_50);
      got = cfg_ready;
      @(posedge sysclk_50);
      #1;
      waited++;
    end
    cfg_req = 1'b0;
    if (got) begin
      acc_at = cyc;
      if (expect_done) push_exp(1'b0, 32'h0, acc_at + 30);
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL write_accept_timeout: waited %0d cycles, required acceptance", waited);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || cfg_ready !== 1'b1) && k < 300) begin
      step(1);
      k++;
    end
    if (k >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d cfg_ready=%0b, required empty and ready", sb.size(), cfg_ready);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a2;
    int k;
    int x;

    // ---- reset
    repeat (3) @(posedge sysclk_50);
    @(negedge sysclk_50);
    check("reset_pins", {cs_n, r_n_w, bus_oe, bus_dout, smp_valid, cfg_done, overrun},
          {1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    check("reset_smp_data", smp_data, 32'h0);
    check("reset_cfg_ready", cfg_ready, 1'b0);
    @(posedge sysclk_50);
    #1;
    i_rest = 1'b0;
    step(2);

    // ---- single write with full waveform check
    do_write(16'h0001, 16'h0000, 1'b1, a);
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk_50);
      if (i < 8) begin
        check("wr_addr_phase", {cs_n, r_n_w, bus_oe}, 3'b011);
        check("wr_addr_data", bus_dout, 16'h0001);
      end else if (i < 16) begin
        check("wr_gap_phase", {cs_n, bus_oe}, 2'b10);
      end else if (i < 24) begin
        check("wr_val_phase", {cs_n, r_n_w, bus_oe}, 3'b011);
        check("wr_val_data", bus_dout, 16'h0000);
      end else begin
        check("wr_settle_phase", {cs_n, bus_oe}, 2'b10);
      end
    end
    wait_idle();

    // ---- single read
    k = cyc;
    cur_msw = 16'h1234;
    cur_lsw = 16'hABCD;
    drdy_n  = 1'b0;
    push_exp(1'b1, 32'h1234ABCD, k + 8);
    @(negedge sysclk_50);
    @(negedge sysclk_50);
    @(negedge sysclk_50);
    check("rd_cs_before", cs_n, 1'b1);
    @(negedge sysclk_50);
    check("rd_cs_start", {cs_n, r_n_w, bus_oe}, 3'b000);
    @(posedge sysclk_50);
    #1;
    drdy_n = 1'b1;
    wait_idle();
    step(3);
    check("rd_smp_hold", smp_data, 32'h1234ABCD);

    // ---- collision: fall and cfg_req on the same IDLE cycle
    k = cyc;
    cur_msw = 16'hCAFE;
    cur_lsw = 16'h0042;
    drdy_n  = 1'b0;
    push_exp(1'b1, 32'hCAFE0042, k + 8);
    step(2);
    do_write(16'h0055, 16'h00AA, 1'b1, a);
    check("collision_accept_cycle", a, k + 9);
    drdy_n = 1'b1;
    wait_idle();

    // ---- fall during W_GAP: read served after the write
    do_write(16'h0010, 16'h0020, 1'b1, a);
    step(9);
    cur_msw = 16'h0F0F;
    cur_lsw = 16'hF0F0;
    drdy_n  = 1'b0;
    push_exp(1'b1, 32'h0F0FF0F0, a + 36);
    step(3);
    drdy_n = 1'b1;
    step(18);
    @(negedge sysclk_50);
    check("wr_then_rd_gap", cs_n, 1'b1);
    @(negedge sysclk_50);
    check("wr_then_rd_start", {cs_n, r_n_w}, 2'b00);
    check("wr_then_rd_no_overrun", overrun, 1'b0);
    wait_idle();
    check("wr_then_rd_overrun_after", overrun, 1'b0);

    // ---- second fall before the queued read starts -> overrun
    do_write(16'h0030, 16'h0040, 1'b1, a2);
    step(9);
    cur_msw = 16'h1111;
    cur_lsw = 16'h2222;
    drdy_n  = 1'b0;
    push_exp(1'b1, 32'h11112222, a2 + 36);
    step(3);
    drdy_n = 1'b1;
    step(3);
    drdy_n = 1'b0;
    step(5);
    @(negedge sysclk_50);
    check("second_fall_overrun", overrun, 1'b1);
    @(posedge sysclk_50);
    #1;
    drdy_n = 1'b1;
    wait_idle();
    step(10);
    check("overrun_sticky", overrun, 1'b1);

    // ---- rd_en=0: overrun clears, DRDY ignored
    rd_en = 1'b0;
    @(posedge sysclk_50);
    @(negedge sysclk_50);
    check("overrun_clear", overrun, 1'b0);
    x = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge sysclk_50);
      #1;
      if (i % 3 == 0) drdy_n = ~drdy_n;
      @(negedge sysclk_50);
      if (cs_n !== 1'b1) x++;
    end
    drdy_n = 1'b1;
    repeat (6) begin
      @(negedge sysclk_50);
      if (cs_n !== 1'b1) x++;
    end
    check("rden0_no_cs_activity", x, 0);
    check("rden0_overrun", overrun, 1'b0);
    step(1);
    rd_en = 1'b1;
    step(5);
    check("rden1_quiet", {cs_n, overrun, cfg_ready}, 3'b101);

    // ---- reset mid-W_VAL aborts without cfg_done
    do_write(16'h0077, 16'h0088, 1'b0, a);
    step(18);
    i_rest = 1'b1;
    step(3);
    i_rest = 1'b0;
    @(negedge sysclk_50);
    check("reset_abort_pins", {cs_n, bus_oe, cfg_ready, cfg_done}, 4'b1010);
    step(40);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
